// File: rtl/pic_pkg.sv
// pic_pkg: register offsets, bus states and id-width helpers shared by the PIC files
package pic_pkg;
  localparam logic [2:0] PIC_IRR    = 3'd0;
  localparam logic [2:0] PIC_IMR    = 3'd1;
  localparam logic [2:0] PIC_ISR    = 3'd2;
  localparam logic [2:0] PIC_MODE   = 3'd3;
  localparam logic [2:0] PIC_VECTOR = 3'd4;
  localparam logic [2:0] PIC_EOI    = 3'd5;
  localparam logic [2:0] PIC_CTRL   = 3'd6;
  localparam int EOI_NSPEC_BIT = 31;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_st_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/pic_prio_enc.sv
// pic_prio_enc: find-first-set, index 0 has the highest priority
module pic_prio_enc import pic_pkg::*; #(
  parameter int N = 8,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    vec,
  output logic [ID_W-1:0] idx,
  output logic            valid
);
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) begin
        idx = ID_W'(i);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/pic_vec_ctrl.sv
// pic_vec_ctrl: vectored, nested interrupt controller with a Wishbone register interface
module pic_vec_ctrl import pic_pkg::*; #(
  parameter int          NUM_IRQ     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  VEC_BASE    = 8'h20
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        adr_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  output logic               int_o,
  input  logic [NUM_IRQ-1:0] irq_i
);
  localparam int N = NUM_IRQ;
  localparam int ID_W = id_width(NUM_IRQ);
  bus_st_e st_q, st_d;
  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0] s_prev_q, irr_q, irr_d, isr_q, isr_d, imr_q, imr_d, mode_q, mode_d;
  logic en_q, en_d, int_q, int_d;
  logic [31:0] dat_q, dat_d;
  logic [ID_W-1:0] p_idx, h_idx;
  logic p_valid, h_valid;
  logic [N-1:0] s, rise, p_hot, h_hot, inta_set, irr_clr, eoi_clr;
  logic acc, rd, wr;
  logic [2:0] reg_sel;
  logic [31:0] wm, wd, rdata;
  logic [7:0] vec_byte;
  logic unused_bits;

  pic_prio_enc #(.N(N), .ID_W(ID_W)) u_p (.vec(irr_q & ~imr_q), .idx(p_idx), .valid(p_valid));
  pic_prio_enc #(.N(N), .ID_W(ID_W)) u_h (.vec(isr_q), .idx(h_idx), .valid(h_valid));

  assign s = sync_q[SYNC_STAGES-1];
  assign dat_o = dat_q;
  assign ack_o = (st_q == BUS_ACK);
  assign int_o = int_q;
  assign unused_bits = ^{adr_i[31:5], adr_i[1:0], wd};

  // decode the access; an INTA set and a new edge win over the clears they race with
  always_comb begin
    acc = cyc_i & stb_i & (st_q == BUS_IDLE);
    rd = acc & ~we_i;
    wr = acc & we_i;
    reg_sel = adr_i[4:2];
    wm = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    wd = dat_i & wm;
    rise = s & ~s_prev_q;
    p_hot = N'(1) << p_idx;
    h_hot = N'(1) << h_idx;
    inta_set = (rd && reg_sel == PIC_VECTOR && p_valid) ? p_hot : '0;
    irr_clr = inta_set & ~mode_q;
    eoi_clr = !(wr && reg_sel == PIC_EOI) ? '0 :
              wd[EOI_NSPEC_BIT] ? (h_valid ? h_hot : '0) :
              sel_i[0] ? N'(32'd1 << wd[4:0]) : '0;
    vec_byte = VEC_BASE + 8'(p_idx);
    rdata = reg_sel == PIC_IRR    ? 32'(irr_q) :
            reg_sel == PIC_IMR    ? 32'(imr_q) :
            reg_sel == PIC_ISR    ? 32'(isr_q) :
            reg_sel == PIC_MODE   ? 32'(mode_q) :
            reg_sel == PIC_VECTOR ? (p_valid ? {1'b1, 23'b0, vec_byte} : {24'b0, VEC_BASE}) :
            reg_sel == PIC_CTRL   ? {31'b0, en_q} : '0;
    st_d = acc ? BUS_ACK : BUS_IDLE;
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    irr_d = (mode_q & s) | (~mode_q & ((irr_q & ~irr_clr) | rise));
    isr_d = (isr_q & ~eoi_clr) | inta_set;
    imr_d = (wr && reg_sel == PIC_IMR) ? (imr_q & ~wm[N-1:0]) | wd[N-1:0] : imr_q;
    mode_d = (wr && reg_sel == PIC_MODE) ? (mode_q & ~wm[N-1:0]) | wd[N-1:0] : mode_q;
    en_d = (wr && reg_sel == PIC_CTRL && sel_i[0]) ? dat_i[0] : en_q;
    int_d = en_q & p_valid & (~h_valid | (p_idx < h_idx));
    dat_d = rd ? rdata : '0;
  end

  // state registers; reset leaves every source masked and the controller disabled
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q <= BUS_IDLE;
      sync_q <= '0;
      s_prev_q <= '0;
      irr_q <= '0;
      isr_q <= '0;
      imr_q <= '1;
      mode_q <= '0;
      en_q <= 1'b0;
      int_q <= 1'b0;
      dat_q <= '0;
    end else begin
      st_q <= st_d;
      sync_q <= sync_d;
      s_prev_q <= s;
      irr_q <= irr_d;
      isr_q <= isr_d;
      imr_q <= imr_d;
      mode_q <= mode_d;
      en_q <= en_d;
      int_q <= int_d;
      dat_q <= dat_d;
    end
  end
endmodule
